mult_pipe: RTL and testbench
============================

Name: mult_pipe

Overview:
- Parametrised successor to the fixed pipelined multiplier.
- Generic XLEN, stage count, tag and branch-mask widths.
- Per-stage valid bits with bubble collapsing, valid/ready backpressure on both sides, and per-stage branch CLEAR/SQUASH.
- Sits in the execute stage between the issue logic and the completion/CDB arbiter. Its results can therefore be held without freezing the whole pipe.

Parameters:
- XLEN, 32, operand/result width; 2*XLEN must be divisible by STAGES.
- STAGES, 4, pipeline depth. Each stage consumes 2*XLEN/STAGES multiplier bits.
- TAG_W, 6, width of the opaque destination tag carried alongside the operands.
- BMASK_W, 4, branch-mask width; one-hot branch IDs.

Ports:
- clock, input, 1, single clock.
- reset, input, 1, asynchronous, active-low reset.
- in_valid, input, 1, operation offered.
- in_ready, output, 1, pipe accepts this cycle.
- in_func, input, 2, MULT_FUNC: M_MUL, M_MULH, M_MULHSU, M_MULHU.
- in_rs1, input, XLEN, multiplicand source.
- in_rs2, input, XLEN, multiplier source.
- in_tag, input, TAG_W, destination tag.
- in_b_mask, input, BMASK_W, branches this op depends on.
- rem_br_task, input, BR_TASK, NOTHING/CLEAR/SQUASH.
- rem_b_id, input, BMASK_W, one-hot resolved branch.
- out_valid, output, 1, result present.
- out_ready, input, 1, consumer takes result.
- out_result, output, XLEN, low half for M_MUL, high half otherwise.
- out_tag, output, TAG_W, tag of the output op.
- out_b_mask, output, BMASK_W, current mask of the output op.
- occupancy, output, clog2(STAGES+1), number of valid stages.

Behaviour:
- Reset (reset==0, asynchronous):
  - All stage valids clear, so out_valid=0 and occupancy=0.
  - in_ready=1 after reset deasserts.
  - Datapath registers are don't-care.
- Operand extension at entry:
  - mcand is sign-extended to 2*XLEN for MUL/MULH/MULHSU, zero-extended for MULHU.
  - mplier is sign-extended for MUL/MULH, zero-extended for MULHSU/MULHU.
- Stage i datapath:
  - sum += mplier[SHIFT-1:0]*mcand, then mplier >>= SHIFT and mcand <<= SHIFT.
  - All arithmetic is modulo 2^(2*XLEN).
  - func, tag and b_mask travel with the data.
- Advance logic (combinational, ripples from the output):
  - adv[S-1] = !v[S-1] | out_ready | kill[S-1].
  - adv[i] = !v[i] | adv[i+1].
  - A stage loads from its predecessor when adv[i]. Otherwise it holds.
  - Empty stages are filled, so bubbles collapse.
- Handshakes:
  - in_ready = adv[0].
  - Accept when in_valid & in_ready.
  - Latency with no backpressure: an op accepted at edge N is at the output after edge N+STAGES-1 (out_valid high STAGES-1 cycles after acceptance). Throughput is 1 op/cycle.
- Output hold: while out_valid & !out_ready, out_result, out_tag and out_b_mask are stable.
- Branch handling: kill[i] = (rem_br_task==SQUASH) & ((mask[i] & rem_b_id) != 0).
  - SQUASH: killed stages clear valid at the edge.
  - SQUASH, same-cycle gating: out_valid = v[S-1] & !kill[S-1]. A squashed op is never handed off.
  - SQUASH on an incoming op: if it matches, in_ready still reflects adv[0] but the op enters with valid=0 (dropped).
  - CLEAR: rem_b_id is removed from every stored mask and from the incoming mask before it is registered. out_b_mask shows the cleared value from the next cycle.
  - A stage's mask updates even while it is held.
- Occupancy: the registered count of valid stages after this edge.
- Simultaneous out handshake and input accept: both occur when the pipe is full and out_ready=1, so throughput is sustained.
- Illegal: rem_b_id with more than one bit set is unspecified (assertion).

Decomposition:
- Shared package (sys_defs) holds: MULT_FUNC enum, BR_TASK enum, XLEN/BMASK_W defaults, and a MULT_STAGE_T struct {valid, func, tag, b_mask, sum, mplier, mcand}.
- Sub-module mult_pipe_stage holds one stage's register and its shift/partial-product logic, with load enable and branch clear/squash inputs.
- The top module holds the extension logic, the advance chain, the output select and occupancy.

Test Plan:
- Single MUL 7*6, no stalls, out_ready=1 → out_valid exactly STAGES-1 cycles after acceptance, out_result=42, tag echoed; then out_valid=0.
- Function sweep with XLEN=32:
  - MULH 0xFFFFFFFF*0xFFFFFFFF → 0x00000000.
  - MULHU same operands → 0xFFFFFFFE.
  - MULHSU 0xFFFFFFFF*0xFFFFFFFF → 0xFFFFFFFF.
  - MUL 0x80000000*2 → 0x00000000.
- Backpressure: out_ready=0 with ops issued every cycle → in_ready drops after the 4th accept, occupancy=4, output stable. Then raise out_ready → results drain in issue order, 1/cycle, with in_ready=1 and no loss.
- Bubble collapse: issue op A, idle 2 cycles, issue op B, out_ready=0 → occupancy reaches 2 and A/B become adjacent, B directly behind A in the last two stages. Releasing out_ready delivers A then B on consecutive cycles.
- Branch: two ops with masks 0001 and 0010 in flight, plus a matching input that same cycle.
  - SQUASH 0001 → the 0001 op never appears, the matching input is dropped, occupancy decrements.
  - CLEAR 0010 → the other op emerges with out_b_mask=0000.
- Reset mid-operation: pipe full and stalled, assert reset low asynchronously → out_valid=0 and occupancy=0 immediately. After release, first new op 3*5 → 15 with normal latency.

Source files
------------

// File: rtl/mult_pipe_pkg.sv
// Shared types for the pipelined multiplier: function and branch-task encodings,
// default widths, and the per-stage record layout at those defaults.
package mult_pipe_pkg;

  localparam int XLEN_DEF    = 32;
  localparam int STAGES_DEF  = 4;
  localparam int TAG_W_DEF   = 6;
  localparam int BMASK_W_DEF = 4;

  typedef enum logic [1:0] {
    M_MUL    = 2'd0,
    M_MULH   = 2'd1,
    M_MULHSU = 2'd2,
    M_MULHU  = 2'd3
  } mult_func_e;

  typedef enum logic [1:0] {
    BR_NOTHING = 2'd0,
    BR_CLEAR   = 2'd1,
    BR_SQUASH  = 2'd2
  } br_task_e;

  typedef struct packed {
    logic                     valid;
    mult_func_e               func;
    logic [TAG_W_DEF-1:0]     tag;
    logic [BMASK_W_DEF-1:0]   b_mask;
    logic [2*XLEN_DEF-1:0]    sum;
    logic [2*XLEN_DEF-1:0]    mplier;
    logic [2*XLEN_DEF-1:0]    mcand;
  } mult_stage_t;

endpackage

// File: rtl/mult_pipe_chk.sv
// Protocol checks on the branch-resolution inputs of the multiplier pipe.
module mult_pipe_chk
  import mult_pipe_pkg::*;
#(
  parameter int BMASK_W = BMASK_W_DEF
) (
  input logic               clock,
  input logic               reset,
  input br_task_e           rem_br_task,
  input logic [BMASK_W-1:0] rem_b_id
);

  a_b_id_onehot: assert property (
    @(posedge clock) disable iff (!reset)
    (rem_br_task != BR_NOTHING) |-> $onehot0(rem_b_id)
  );

endmodule

// File: rtl/mult_pipe_stage.sv
// One multiplier stage: folds the low SHIFT multiplier bits into the running sum
// and shifts the operands on load; holds otherwise while tracking branch updates.
module mult_pipe_stage
  import mult_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int BMASK_W = BMASK_W_DEF
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               load,
  input  logic               kill,
  input  logic [BMASK_W-1:0] clr_mask,
  input  logic               prev_valid,
  input  logic               prev_kill,
  input  mult_func_e         prev_func,
  input  logic [TAG_W-1:0]   prev_tag,
  input  logic [BMASK_W-1:0] prev_mask,
  input  logic [2*XLEN-1:0]  prev_sum,
  input  logic [2*XLEN-1:0]  prev_mplier,
  input  logic [2*XLEN-1:0]  prev_mcand,
  output logic               valid_nxt,
  output logic               valid_r,
  output mult_func_e         func_r,
  output logic [TAG_W-1:0]   tag_r,
  output logic [BMASK_W-1:0] mask_r,
  output logic [2*XLEN-1:0]  sum_r,
  output logic [2*XLEN-1:0]  mplier_r,
  output logic [2*XLEN-1:0]  mcand_r
);

  localparam int W2    = 2 * XLEN;
  localparam int SHIFT = W2 / STAGES;

  logic [W2-1:0] pp_s;
  logic [W2-1:0] sum_nxt_s;

  // Partial product and next valid (a killed predecessor enters as a bubble)
  always_comb begin
    pp_s      = W2'(prev_mplier[SHIFT-1:0]) * prev_mcand;
    sum_nxt_s = prev_sum + pp_s;
    if (load) begin
      valid_nxt = prev_valid & ~prev_kill;
    end else begin
      valid_nxt = valid_r & ~kill;
    end
  end

  // Stage register; the mask is cleaned every cycle, even while holding
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      valid_r  <= 1'b0;
      func_r   <= M_MUL;
      tag_r    <= {TAG_W{1'b0}};
      mask_r   <= {BMASK_W{1'b0}};
      sum_r    <= {W2{1'b0}};
      mplier_r <= {W2{1'b0}};
      mcand_r  <= {W2{1'b0}};
    end else begin
      valid_r <= valid_nxt;
      if (load) begin
        func_r   <= prev_func;
        tag_r    <= prev_tag;
        mask_r   <= prev_mask & ~clr_mask;
        sum_r    <= sum_nxt_s;
        mplier_r <= prev_mplier >> SHIFT;
        mcand_r  <= prev_mcand << SHIFT;
      end else begin
        mask_r <= mask_r & ~clr_mask;
      end
    end
  end

endmodule

// File: rtl/mult_pipe.sv
// Parametrised pipelined multiplier with bubble-collapsing valid/ready stages and
// per-stage branch clear/squash. 2*XLEN must be a multiple of STAGES.
module mult_pipe
  import mult_pipe_pkg::*;
#(
  parameter int XLEN    = XLEN_DEF,
  parameter int STAGES  = STAGES_DEF,
  parameter int TAG_W   = TAG_W_DEF,
  parameter int BMASK_W = BMASK_W_DEF
) (
  input  logic                          clock,
  input  logic                          reset,
  input  logic                          in_valid,
  output logic                          in_ready,
  input  mult_func_e                    in_func,
  input  logic [XLEN-1:0]               in_rs1,
  input  logic [XLEN-1:0]               in_rs2,
  input  logic [TAG_W-1:0]              in_tag,
  input  logic [BMASK_W-1:0]            in_b_mask,
  input  br_task_e                      rem_br_task,
  input  logic [BMASK_W-1:0]            rem_b_id,
  output logic                          out_valid,
  input  logic                          out_ready,
  output logic [XLEN-1:0]               out_result,
  output logic [TAG_W-1:0]              out_tag,
  output logic [BMASK_W-1:0]            out_b_mask,
  output logic [$clog2(STAGES+1)-1:0]   occupancy
);

  localparam int W2    = 2 * XLEN;
  localparam int OCC_W = $clog2(STAGES + 1);

  logic [W2-1:0]      mcand_ext_s;
  logic [W2-1:0]      mplier_ext_s;
  logic               squash_s;
  logic               kill_in_s;
  logic [BMASK_W-1:0] clr_mask_s;
  logic [STAGES-1:0]  adv_s;
  logic [OCC_W-1:0]   occ_nxt_s;

  logic               kill_s       [STAGES];
  logic               valid_nxt_s  [STAGES];
  logic               valid_r      [STAGES];
  mult_func_e         func_r       [STAGES];
  logic [TAG_W-1:0]   tag_r        [STAGES];
  logic [BMASK_W-1:0] mask_r       [STAGES];
  logic [W2-1:0]      sum_r        [STAGES];
  logic [W2-1:0]      mplier_r     [STAGES];
  logic [W2-1:0]      mcand_r      [STAGES];

  logic               prev_valid_s  [STAGES];
  logic               prev_kill_s   [STAGES];
  mult_func_e         prev_func_s   [STAGES];
  logic [TAG_W-1:0]   prev_tag_s    [STAGES];
  logic [BMASK_W-1:0] prev_mask_s   [STAGES];
  logic [W2-1:0]      prev_sum_s    [STAGES];
  logic [W2-1:0]      prev_mplier_s [STAGES];
  logic [W2-1:0]      prev_mcand_s  [STAGES];

  // Operand extension: only MULHU treats rs1 as unsigned, MULHSU/MULHU treat rs2 so
  always_comb begin
    mcand_ext_s  = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
    mplier_ext_s = {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
    case (in_func)
      M_MUL, M_MULH: begin
        mcand_ext_s  = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
        mplier_ext_s = {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
      end
      M_MULHSU: begin
        mcand_ext_s  = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
        mplier_ext_s = {{XLEN{1'b0}}, in_rs2};
      end
      M_MULHU: begin
        mcand_ext_s  = {{XLEN{1'b0}}, in_rs1};
        mplier_ext_s = {{XLEN{1'b0}}, in_rs2};
      end
      default: begin
        mcand_ext_s  = {{XLEN{in_rs1[XLEN-1]}}, in_rs1};
        mplier_ext_s = {{XLEN{in_rs2[XLEN-1]}}, in_rs2};
      end
    endcase
  end

  // Branch resolution: per-stage kill and mask clearing
  always_comb begin
    squash_s   = (rem_br_task == BR_SQUASH);
    clr_mask_s = (rem_br_task == BR_CLEAR) ? rem_b_id : {BMASK_W{1'b0}};
    kill_in_s  = squash_s & (|(in_b_mask & rem_b_id));
    for (int i = 0; i < STAGES; i++) begin
      kill_s[i] = squash_s & (|(mask_r[i] & rem_b_id));
    end
  end

  // Advance chain ripples back from the output; a killed tail may be overwritten
  always_comb begin : adv_chain
    logic carry_v;
    carry_v            = ~valid_r[STAGES-1] | out_ready | kill_s[STAGES-1];
    adv_s              = {STAGES{1'b0}};
    adv_s[STAGES-1]    = carry_v;
    for (int i = STAGES - 2; i >= 0; i--) begin
      carry_v  = ~valid_r[i] | carry_v;
      adv_s[i] = carry_v;
    end
  end

  // Predecessor of stage 0 is the extended input with an empty running sum
  always_comb begin
    prev_valid_s[0]  = in_valid;
    prev_kill_s[0]   = kill_in_s;
    prev_func_s[0]   = in_func;
    prev_tag_s[0]    = in_tag;
    prev_mask_s[0]   = in_b_mask;
    prev_sum_s[0]    = {W2{1'b0}};
    prev_mplier_s[0] = mplier_ext_s;
    prev_mcand_s[0]  = mcand_ext_s;
    for (int i = 1; i < STAGES; i++) begin
      prev_valid_s[i]  = valid_r[i-1];
      prev_kill_s[i]   = kill_s[i-1];
      prev_func_s[i]   = func_r[i-1];
      prev_tag_s[i]    = tag_r[i-1];
      prev_mask_s[i]   = mask_r[i-1];
      prev_sum_s[i]    = sum_r[i-1];
      prev_mplier_s[i] = mplier_r[i-1];
      prev_mcand_s[i]  = mcand_r[i-1];
    end
  end

  for (genvar g = 0; g < STAGES; g++) begin : g_stage
    mult_pipe_stage #(
      .XLEN    (XLEN),
      .STAGES  (STAGES),
      .TAG_W   (TAG_W),
      .BMASK_W (BMASK_W)
    ) u_stage (
      .clock       (clock),
      .reset       (reset),
      .load        (adv_s[g]),
      .kill        (kill_s[g]),
      .clr_mask    (clr_mask_s),
      .prev_valid  (prev_valid_s[g]),
      .prev_kill   (prev_kill_s[g]),
      .prev_func   (prev_func_s[g]),
      .prev_tag    (prev_tag_s[g]),
      .prev_mask   (prev_mask_s[g]),
      .prev_sum    (prev_sum_s[g]),
      .prev_mplier (prev_mplier_s[g]),
      .prev_mcand  (prev_mcand_s[g]),
      .valid_nxt   (valid_nxt_s[g]),
      .valid_r     (valid_r[g]),
      .func_r      (func_r[g]),
      .tag_r       (tag_r[g]),
      .mask_r      (mask_r[g]),
      .sum_r       (sum_r[g]),
      .mplier_r    (mplier_r[g]),
      .mcand_r     (mcand_r[g])
    );
  end

  assign in_ready   = adv_s[0];
  assign out_valid  = valid_r[STAGES-1] & ~kill_s[STAGES-1];
  assign out_tag    = tag_r[STAGES-1];
  assign out_b_mask = mask_r[STAGES-1];
  assign out_result = (func_r[STAGES-1] == M_MUL) ? sum_r[STAGES-1][XLEN-1:0]
                                                  : sum_r[STAGES-1][W2-1:XLEN];

  // Count of stages that will be valid after this edge
  always_comb begin
    occ_nxt_s = {OCC_W{1'b0}};
    for (int i = 0; i < STAGES; i++) begin
      occ_nxt_s = occ_nxt_s + OCC_W'(valid_nxt_s[i]);
    end
  end

  // Occupancy register
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      occupancy <= {OCC_W{1'b0}};
    end else begin
      occupancy <= occ_nxt_s;
    end
  end

  mult_pipe_chk #(
    .BMASK_W (BMASK_W)
  ) u_chk (
    .clock       (clock),
    .reset       (reset),
    .rem_br_task (rem_br_task),
    .rem_b_id    (rem_b_id)
  );

endmodule

// File: tb/tb_mult_pipe.sv
// Self-checking bench for mult_pipe: vector table through a scoreboard plus
// hand-written latency, backpressure, bubble, branch and reset sequences.
module tb_mult_pipe;
  import mult_pipe_pkg::*;

  localparam int XLEN    = 32;
  localparam int STAGES  = 4;
  localparam int TAG_W   = 6;
  localparam int BMASK_W = 4;
  localparam int OCC_W   = $clog2(STAGES + 1);

  logic               clock = 1'b0;
  logic               reset;
  logic               in_valid;
  logic               in_ready;
  mult_func_e         in_func;
  logic [XLEN-1:0]    in_rs1;
  logic [XLEN-1:0]    in_rs2;
  logic [TAG_W-1:0]   in_tag;
  logic [BMASK_W-1:0] in_b_mask;
  br_task_e           rem_br_task;
  logic [BMASK_W-1:0] rem_b_id;
  logic               out_valid;
  logic               out_ready;
  logic [XLEN-1:0]    out_result;
  logic [TAG_W-1:0]   out_tag;
  logic [BMASK_W-1:0] out_b_mask;
  logic [OCC_W-1:0]   occupancy;

  int checks = 0;
  int errors = 0;
  logic [XLEN-1:0] cur_exp;

  typedef struct {
    logic [XLEN-1:0]    res;
    logic [TAG_W-1:0]   tag;
    logic [BMASK_W-1:0] mask;
  } exp_t;
  exp_t sb[$];
  exp_t mon_e;
  logic mon_in_kill;

  typedef struct {
    mult_func_e      func;
    logic [XLEN-1:0] a;
    logic [XLEN-1:0] b;
    logic [XLEN-1:0] exp;
  } vec_t;
  vec_t vecs[10];

  mult_pipe #(
    .XLEN(XLEN), .STAGES(STAGES), .TAG_W(TAG_W), .BMASK_W(BMASK_W)
  ) dut (
    .clock(clock), .reset(reset),
    .in_valid(in_valid), .in_ready(in_ready), .in_func(in_func),
    .in_rs1(in_rs1), .in_rs2(in_rs2), .in_tag(in_tag), .in_b_mask(in_b_mask),
    .rem_br_task(rem_br_task), .rem_b_id(rem_b_id),
    .out_valid(out_valid), .out_ready(out_ready), .out_result(out_result),
    .out_tag(out_tag), .out_b_mask(out_b_mask), .occupancy(occupancy)
  );

  always #5 clock = ~clock;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Scoreboard: pop on output handshake, apply branch updates, push on accept
  always @(negedge clock) begin
    if (!reset) begin
      sb.delete();
    end else begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_out: tag 0x%0h with empty scoreboard", out_tag);
        end else begin
          mon_e = sb.pop_front();
          check("out_result", out_result, mon_e.res);
          check("out_tag", out_tag, mon_e.tag);
          check("out_b_mask", out_b_mask, mon_e.mask);
        end
      end
      mon_in_kill = (rem_br_task == BR_SQUASH) && ((in_b_mask & rem_b_id) != 0);
      if (rem_br_task == BR_SQUASH) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
          if ((sb[i].mask & rem_b_id) != 0) sb.delete(i);
        end
      end
      if (rem_br_task == BR_CLEAR) begin
        for (int i = 0; i < sb.size(); i++) sb[i].mask = sb[i].mask & ~rem_b_id;
      end
      if (in_valid && in_ready && !mon_in_kill) begin
        mon_e.res  = cur_exp;
        mon_e.tag  = in_tag;
        mon_e.mask = (rem_br_task == BR_CLEAR) ? (in_b_mask & ~rem_b_id) : in_b_mask;
        sb.push_back(mon_e);
      end
    end
  end

  task automatic issue(input mult_func_e f, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                       input logic [TAG_W-1:0] t, input logic [BMASK_W-1:0] m,
                       input logic [XLEN-1:0] e);
    logic acc;
    int   tries;
    in_func = f; in_rs1 = a; in_rs2 = b; in_tag = t; in_b_mask = m; cur_exp = e;
    in_valid = 1'b1;
    acc = 1'b0;
    tries = 0;
    while (!acc && tries < 50) begin
      @(negedge clock);
      acc = in_ready;
      @(posedge clock); #1;
      tries++;
    end
    in_valid = 1'b0;
    check("issue_accept", acc, 1);
  endtask

  task automatic wait_out(output int lat);
    lat = 0;
    while (!out_valid && lat < 20) begin
      @(posedge clock); #1;
      lat++;
    end
  endtask

  task automatic drain(input string name);
    int n;
    n = 0;
    while (sb.size() != 0 && n < 40) begin
      @(posedge clock); #1;
      n++;
    end
    check(name, sb.size(), 0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat;
    int cnt;
    logic rdy;

    vecs[0] = '{M_MUL,    32'd7,          32'd6,          32'd42};
    vecs[1] = '{M_MULH,   32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'h0000_0000};
    vecs[2] = '{M_MULHU,  32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFE};
    vecs[3] = '{M_MULHSU, 32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'hFFFF_FFFF};
    vecs[4] = '{M_MUL,    32'h8000_0000,  32'd2,          32'h0000_0000};
    vecs[5] = '{M_MULH,   32'hFFFF_FFFE,  32'd3,          32'hFFFF_FFFF};
    vecs[6] = '{M_MULHU,  32'h8000_0000,  32'd4,          32'h0000_0002};
    vecs[7] = '{M_MULHSU, 32'h8000_0000,  32'h8000_0000,  32'hC000_0000};
    vecs[8] = '{M_MUL,    32'h1234_5678,  32'h0000_0010,  32'h2345_6780};
    vecs[9] = '{M_MULH,   32'h4000_0000,  32'h4000_0000,  32'h1000_0000};

    reset = 1'b0; in_valid = 1'b0; out_ready = 1'b1; in_func = M_MUL;
    in_rs1 = 32'd0; in_rs2 = 32'd0; in_tag = 6'd0; in_b_mask = 4'd0;
    rem_br_task = BR_NOTHING; rem_b_id = 4'd0; cur_exp = 32'd0;

    #12;
    check("rst_out_valid", out_valid, 0);
    check("rst_occupancy", occupancy, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    @(posedge clock); #1;
    check("rst_in_ready", in_ready, 1);

    // single op latency
    issue(M_MUL, 32'd7, 32'd6, 6'd5, 4'd0, 32'd42);
    wait_out(lat);
    check("mul_latency", lat, STAGES - 1);
    check("mul_result", out_result, 32'd42);
    check("mul_tag", out_tag, 6'd5);
    @(posedge clock); #1;
    check("mul_out_valid_low", out_valid, 0);

    // function sweep
    for (int i = 0; i < 10; i++) begin
      issue(vecs[i].func, vecs[i].a, vecs[i].b, TAG_W'(i + 1), 4'd0, vecs[i].exp);
    end
    drain("sweep_drain");

    // backpressure
    out_ready = 1'b0;
    for (int k = 0; k < 5; k++) begin
      in_func = M_MUL; in_rs1 = XLEN'(k + 2); in_rs2 = XLEN'(k + 3);
      in_tag = TAG_W'(10 + k); in_b_mask = 4'd0; cur_exp = XLEN'((k + 2) * (k + 3));
      in_valid = 1'b1;
      @(negedge clock);
      rdy = in_ready;
      check($sformatf("bp_in_ready_%0d", k), rdy, (k < 4) ? 1 : 0);
      @(posedge clock); #1;
    end
    check("bp_occupancy", occupancy, 4);
    check("bp_out_valid", out_valid, 1);
    repeat (2) begin
      @(posedge clock); #1;
    end
    check("bp_hold_result", out_result, 32'd6);
    check("bp_hold_tag", out_tag, 6'd10);
    check("bp_hold_in_ready", in_ready, 0);
    out_ready = 1'b1;
    #1;
    check("bp_release_in_ready", in_ready, 1);
    cnt = 0;
    for (int j = 0; j < 5; j++) begin
      if (out_valid) cnt++;
      @(posedge clock); #1;
      if (j == 0) in_valid = 1'b0;
    end
    check("bp_drain_count", cnt, 5);
    drain("bp_drain");

    // bubble collapse
    out_ready = 1'b0;
    issue(M_MULHU, 32'hFFFF_FFFF, 32'd2, 6'd20, 4'd0, 32'd1);
    repeat (2) begin
      @(posedge clock); #1;
    end
    issue(M_MUL, 32'd100, 32'd100, 6'd21, 4'd0, 32'd10000);
    repeat (3) begin
      @(posedge clock); #1;
    end
    check("bub_occupancy", occupancy, 2);
    check("bub_head_tag", out_tag, 6'd20);
    check("bub_in_ready", in_ready, 1);
    out_ready = 1'b1;
    #1;
    check("bub_a_valid", out_valid, 1);
    check("bub_a_tag", out_tag, 6'd20);
    @(posedge clock); #1;
    check("bub_b_valid", out_valid, 1);
    check("bub_b_tag", out_tag, 6'd21);
    check("bub_b_result", out_result, 32'd10000);
    @(posedge clock); #1;
    check("bub_empty", out_valid, 0);

    // branch squash then clear
    out_ready = 1'b0;
    issue(M_MUL, 32'd3, 32'd4, 6'd30, 4'b0001, 32'd12);
    issue(M_MUL, 32'd5, 32'd6, 6'd31, 4'b0010, 32'd30);
    check("br_occ_before", occupancy, 2);
    in_func = M_MUL; in_rs1 = 32'd9; in_rs2 = 32'd9; in_tag = 6'd32;
    in_b_mask = 4'b0001; cur_exp = 32'd81; in_valid = 1'b1;
    rem_br_task = BR_SQUASH; rem_b_id = 4'b0001;
    #1;
    check("br_squash_in_ready", in_ready, 1);
    @(posedge clock); #1;
    in_valid = 1'b0;
    rem_br_task = BR_CLEAR; rem_b_id = 4'b0010;
    check("br_occ_after_squash", occupancy, 1);
    @(posedge clock); #1;
    rem_br_task = BR_NOTHING; rem_b_id = 4'd0;
    check("br_occ_after_clear", occupancy, 1);
    out_ready = 1'b1;
    wait_out(lat);
    check("br_out_valid", out_valid, 1);
    check("br_tag", out_tag, 6'd31);
    check("br_mask_cleared", out_b_mask, 4'b0000);
    check("br_result", out_result, 32'd30);
    drain("br_drain");
    @(posedge clock); #1;
    check("br_no_squashed_out", out_valid, 0);

    // asynchronous reset mid-operation
    out_ready = 1'b0;
    for (int k = 0; k < 4; k++) begin
      issue(M_MUL, XLEN'(k + 1), XLEN'(k + 1), TAG_W'(40 + k), 4'd0, XLEN'((k + 1) * (k + 1)));
    end
    check("rst2_occ_full", occupancy, 4);
    check("rst2_valid_full", out_valid, 1);
    @(posedge clock); #3;
    reset = 1'b0;
    #1;
    check("rst2_out_valid", out_valid, 0);
    check("rst2_occupancy", occupancy, 0);
    @(posedge clock); #1;
    reset = 1'b1;
    out_ready = 1'b1;
    #1;
    check("rst2_in_ready", in_ready, 1);
    issue(M_MUL, 32'd3, 32'd5, 6'd50, 4'd0, 32'd15);
    wait_out(lat);
    check("rst2_latency", lat, STAGES - 1);
    check("rst2_result", out_result, 32'd15);
    drain("rst2_drain");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
